// File: rtl/sign_narrow.sv
// Narrows a signed IN_W word to OUT_W with truncate/saturate policy, buffered in a small FIFO.
// Optional overflow statistics counter: define SIGN_NARROW_STATS_EN to build it.
module sign_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             sat_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // in_ready and out_valid depend only on the registered count, so neither
    // side has a combinational path to the other.

    logic [IN_W-OUT_W:0] upper;
    logic                ovf;
    logic [OUT_W-1:0]    sat_val;
    logic [OUT_W-1:0]    narrowed;

    always_comb begin
        upper    = in_data[IN_W-1:OUT_W-1];
        ovf      = ~(&upper | ~|upper);
        sat_val  = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        narrowed = (sat_mode && ovf) ? sat_val : in_data[OUT_W-1:0];
    end

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic             mem_ovf  [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_data[rd_ptr];
    assign out_ovf   = mem_ovf[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_ovf[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= narrowed;
                mem_ovf[wr_ptr]  <= ovf;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SIGN_NARROW_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ovf_count <= '0;
        end else if (push && ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_sign_narrow.sv
// Directed bench for sign_narrow: tracks FIFO occupancy and an expected queue of
// hand-computed {ovf,data} results, checking every cycle against them.
module tb_sign_narrow;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sat_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic [7:0]  ovf_count;

    int n_cmp;
    int n_bad;

    logic [16:0] exp_q[$];
    int          exp_ovf_cnt;
    int          idx;
    logic        acc;

    sign_narrow #(.IN_W(32), .OUT_W(16), .DEPTH(2), .CNT_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sat_mode  (sat_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int max_cnt_exp(input int c);
`ifdef SIGN_NARROW_STATS_EN
        return (c > 255) ? 255 : c;
`else
        return (c > 0) ? 0 : 0;
`endif
    endfunction

    // One clock: drive, predict acceptance from bench occupancy, step, then check.
    task automatic cyc(input logic v, input logic [31:0] d, input logic s, input logic r,
                       input logic [16:0] e, output logic accepted);
        logic popped;
        in_valid  = v;
        in_data   = d;
        sat_mode  = s;
        out_ready = r;
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
        accepted = v && (exp_q.size() < 2);
        popped   = r && (exp_q.size() > 0);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        if (popped) void'(exp_q.pop_front());
        if (accepted) begin
            exp_q.push_back(e);
            if (e[16]) exp_ovf_cnt++;
        end
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("out_data", {16'b0, out_data}, {16'b0, exp_q[0][15:0]});
            check("out_ovf", {31'b0, out_ovf}, {31'b0, exp_q[0][16]});
        end
        check("ovf_count", {24'b0, ovf_count}, max_cnt_exp(exp_ovf_cnt));
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        repeat (cycles) @(posedge Clk);
        #1;
        Reset = 1'b0;
        exp_q.delete();
        exp_ovf_cnt = 0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        exp_ovf_cnt = 0;
        Reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        sat_mode    = 1'b0;
        out_ready   = 1'b0;
        @(negedge Clk);
        do_reset(2);

        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
        check("rst_ovf_count", {24'b0, ovf_count}, 32'd0);

        // Basic in-range word, then drain.
        cyc(1'b1, 32'h0000_1234, 1'b0, 1'b0, {1'b0, 16'h1234}, acc);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);

        // Representable extremes, back to back with pop.
        cyc(1'b1, 32'hFFFF_8000, 1'b0, 1'b1, {1'b0, 16'h8000}, acc);
        cyc(1'b1, 32'h0000_7FFF, 1'b0, 1'b1, {1'b0, 16'h7FFF}, acc);
        cyc(1'b1, 32'hFFFF_8000, 1'b1, 1'b1, {1'b0, 16'h8000}, acc);
        cyc(1'b1, 32'h0000_7FFF, 1'b1, 1'b1, {1'b0, 16'h7FFF}, acc);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);

        // Overflowing words in both policies, including just-out-of-range values.
        cyc(1'b1, 32'h0001_2345, 1'b0, 1'b1, {1'b1, 16'h2345}, acc);
        cyc(1'b1, 32'h0001_2345, 1'b1, 1'b1, {1'b1, 16'h7FFF}, acc);
        cyc(1'b1, 32'h8000_0000, 1'b1, 1'b1, {1'b1, 16'h8000}, acc);
        cyc(1'b1, 32'h8000_0000, 1'b0, 1'b1, {1'b1, 16'h0000}, acc);
        cyc(1'b1, 32'h0000_8000, 1'b0, 1'b1, {1'b1, 16'h8000}, acc);
        cyc(1'b1, 32'h0000_8000, 1'b1, 1'b1, {1'b1, 16'h7FFF}, acc);
        cyc(1'b1, 32'hFFFF_7FFF, 1'b0, 1'b1, {1'b1, 16'h7FFF}, acc);
        cyc(1'b1, 32'hFFFF_7FFF, 1'b1, 1'b1, {1'b1, 16'h8000}, acc);
        cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, {1'b0, 16'hFFFF}, acc);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);

        // Stall with out_ready low, then stream with the producer holding each word.
        idx = 0;
        repeat (3) begin
            cyc(1'b1, 32'h0000_0100 + idx, 1'b0, 1'b0, {1'b0, 16'h0100 + 16'(idx)}, acc);
            if (acc) idx++;
        end
        check("stall_accepted", idx, 2);
        for (int c = 0; c < 16 && idx < 9; c++) begin
            cyc(1'b1, 32'h0000_0100 + idx, 1'b0, 1'b1, {1'b0, 16'h0100 + 16'(idx)}, acc);
            if (acc) idx++;
        end
        check("stream_accepted", idx, 9);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);

        // Fill, then reset with a push and pop pending: nothing survives.
        cyc(1'b1, 32'h0000_0AAA, 1'b0, 1'b0, {1'b0, 16'h0AAA}, acc);
        cyc(1'b1, 32'h0000_0BBB, 1'b0, 1'b0, {1'b0, 16'h0BBB}, acc);
        in_valid  = 1'b1;
        in_data   = 32'h0000_0CCC;
        out_ready = 1'b1;
        do_reset(1);
        in_valid = 1'b0;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);
        cyc(1'b1, 32'h0000_0DDD, 1'b0, 1'b0, {1'b0, 16'h0DDD}, acc);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);

        // Counter saturation over 300 overflowing words.
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 32'h0001_0000 + i, 1'b0, 1'b1, {1'b1, 16'(i)}, acc);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 17'h0, acc);
`ifdef SIGN_NARROW_STATS_EN
        check("ovf_count_sat", {24'b0, ovf_count}, 32'd255);
`else
        check("ovf_count_off", {24'b0, ovf_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
